// File: rtl/mau_pkg.sv
// mau_pkg: shared type codes, FSM states and helpers for the memory access unit
package mau_pkg;

    typedef enum logic [2:0] {
        LT_LB  = 3'b000,
        LT_LH  = 3'b001,
        LT_LW  = 3'b010,
        LT_LBU = 3'b011,
        LT_LHU = 3'b100,
        LT_DEF = 3'b111
    } load_type_e;

    typedef enum logic [1:0] {
        ST_SB  = 2'b00,
        ST_SH  = 2'b01,
        ST_SW  = 2'b10,
        ST_DEF = 2'b11
    } store_type_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_e;

    localparam logic [31:0] ZERO_32BIT = 32'h0000_0000;

    // True when the access size does not fit the low address bits
    function automatic logic mau_misaligned(input logic we, input logic [2:0] lt,
                                            input logic [1:0] st, input logic [1:0] lo);
        logic half, word;
        half = we ? (st == ST_SH) : (lt == LT_LH || lt == LT_LHU);
        word = we ? (st == ST_SW) : (lt == LT_LW);
        return (half & lo[0]) | (word & (lo != 2'b00));
    endfunction

endpackage

// File: rtl/mau_align.sv
// mau_align: store lane steering and load byte/half extraction with extension
module mau_align
    import mau_pkg::*;
(
    input  logic        we_i,
    input  logic [1:0]  st_i,
    input  logic [1:0]  s_lo_i,
    input  logic [31:0] sd_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    input  logic [2:0]  lt_i,
    input  logic [1:0]  l_lo_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] ldata_o
);
    logic [7:0]  b;
    logic [15:0] h;

    // Byte enables and replicated write data; reads never enable lanes
    always_comb begin
        be_o    = !we_i           ? 4'b0000 :
                  st_i == ST_SB   ? 4'b0001 << s_lo_i :
                  st_i == ST_SH   ? (s_lo_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata_o = st_i == ST_SB ? {4{sd_i[7:0]}} :
                  st_i == ST_SH ? {2{sd_i[15:0]}} : sd_i;
    end

    // Pick the addressed byte/half out of the returned word and extend it
    always_comb begin
        b       = 8'(rdata_i >> {l_lo_i, 3'b000});
        h       = 16'(rdata_i >> {l_lo_i[1], 4'b0000});
        ldata_o = lt_i == LT_LB  ? {{24{b[7]}}, b} :
                  lt_i == LT_LBU ? {24'h0, b} :
                  lt_i == LT_LH  ? {{16{h[15]}}, h} :
                  lt_i == LT_LHU ? {16'h0, h} : rdata_i;
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store FSM with dmem handshake; MAU_MISALIGN_TRAP_EN enables misalignment trapping
module mem_access_unit
    import mau_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  mem_load_type,
    input  logic [1:0]  mem_store_type,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        load_valid,
    output logic [31:0] load_data,
    output logic        misaligned
);
    state_e      state_q, state_d;
    logic        accept, trap, trap_q, we_q, req_q;
    logic [2:0]  lt_q;
    logic [3:0]  be_q, be_d;
    logic [31:0] addr_q, wdata_q, wdata_d, ld_q, ld_d;

    assign accept = ex_valid & (mem_write ? mem_store_type != ST_DEF
                                          : mem_read & (mem_load_type != LT_DEF));
`ifdef MAU_MISALIGN_TRAP_EN
    assign trap = mau_misaligned(mem_write, mem_load_type, mem_store_type, addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    mau_align u_align (
        .we_i    (mem_write),
        .st_i    (mem_store_type),
        .s_lo_i  (addr[1:0]),
        .sd_i    (store_data),
        .be_o    (be_d),
        .wdata_o (wdata_d),
        .lt_i    (lt_q),
        .l_lo_i  (addr_q[1:0]),
        .rdata_i (dmem_rdata),
        .ldata_o (ld_d)
    );

    // Next state: trapped accesses skip the memory entirely
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = accept ? (trap ? S_DONE : S_REQ) : S_IDLE;
            S_REQ:   state_d = dmem_gnt ? (we_q ? S_DONE : S_WAIT) : S_REQ;
            S_WAIT:  state_d = dmem_rvalid ? S_DONE : S_WAIT;
            default: state_d = S_IDLE;
        endcase
    end

    // State, latched request fields and registered load result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            trap_q  <= 1'b0;
            lt_q    <= 3'b000;
            be_q    <= 4'b0000;
            addr_q  <= ZERO_32BIT;
            wdata_q <= ZERO_32BIT;
            ld_q    <= ZERO_32BIT;
        end else begin
            state_q <= state_d;
            req_q   <= state_d == S_REQ;
            if (state_q == S_IDLE && accept) begin
                we_q    <= mem_write;
                trap_q  <= trap;
                lt_q    <= mem_load_type;
                be_q    <= be_d;
                addr_q  <= addr;
                wdata_q <= wdata_d;
                if (trap) ld_q <= ZERO_32BIT;
            end
            if (state_q == S_WAIT && dmem_rvalid) ld_q <= ld_d;
        end
    end

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_be    = be_q;
    assign dmem_addr  = {addr_q[31:2], 2'b00};
    assign dmem_wdata = wdata_q;
    assign load_data  = ld_q;
    assign load_valid = (state_q == S_DONE) & ~we_q;
    assign misaligned = (state_q == S_DONE) & trap_q;
    assign mem_stall  = (state_q == S_REQ) | (state_q == S_WAIT) | ((state_q == S_IDLE) & accept);

endmodule
